// File: rtl/elevator_request_queue_if.sv
// Request/queue-status bundle between the button-scan front end, the
// elevator request queue and the motion controller.
interface elevator_request_queue_if #(
    parameter int unsigned NUM_LVLS = 4,
    parameter int unsigned DEPTH    = 4
);
    localparam int unsigned LVL_W = (NUM_LVLS > 1) ? $clog2(NUM_LVLS) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                     add_new_lvl;
    logic [LVL_W-1:0]         pressed_lvl;
    logic                     pop;
    logic [DEPTH*LVL_W-1:0]   queue;
    logic [CNT_W-1:0]         count;
    logic [LVL_W-1:0]         head_lvl;
    logic                     head_valid;
    logic                     full;
    logic                     empty;
    logic [NUM_LVLS-1:0]      pending;
    logic                     dup_drop;
    logic                     ovf_drop;

    modport master (
        output add_new_lvl, pressed_lvl, pop,
        input  queue, count, head_lvl, head_valid, full, empty, pending,
               dup_drop, ovf_drop
    );

    modport slave (
        input  add_new_lvl, pressed_lvl, pop,
        output queue, count, head_lvl, head_valid, full, empty, pending,
               dup_drop, ovf_drop
    );
endinterface

// File: rtl/elevator_request_queue.sv
// Registered FIFO of pending floor requests with duplicate suppression;
// the oldest request is presented at entry 0 and retired by pop.
module elevator_request_queue #(
    parameter int unsigned NUM_LVLS = 4,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    elevator_request_queue_if.slave  bus
);
    localparam int unsigned LVL_W = (NUM_LVLS > 1) ? $clog2(NUM_LVLS) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][LVL_W-1:0] q_r, q_pp, q_nxt;
    logic [CNT_W-1:0]            cnt_r, cnt_pp, cnt_nxt;
    logic [NUM_LVLS-1:0]         pend_r, pend_pp, pend_nxt;
    logic [NUM_LVLS-1:0]         req_oh, head_oh;
    logic                        dup_r, dup_nxt;
    logic                        ovf_r, ovf_nxt;
    logic                        full_r, full_nxt;
    logic                        empty_r, empty_nxt;
    logic                        hv_r, hv_nxt;
    logic                        do_pop, oor, is_dup, is_full;
    logic [LVL_W:0]              lvl_ext;

    // Pop is applied first; the add is then evaluated against post-pop state.
    always_comb begin
        q_pp      = q_r;
        cnt_pp    = cnt_r;
        pend_pp   = pend_r;
        q_nxt     = q_r;
        cnt_nxt   = cnt_r;
        pend_nxt  = pend_r;
        dup_nxt   = 1'b0;
        ovf_nxt   = 1'b0;
        req_oh    = '0;
        head_oh   = '0;
        lvl_ext   = {1'b0, bus.pressed_lvl};
        do_pop    = bus.pop && (cnt_r != '0);
        oor       = lvl_ext >= (LVL_W+1)'(NUM_LVLS);

        for (int i = 0; i < int'(NUM_LVLS); i++) begin
            req_oh[i]  = (bus.pressed_lvl == LVL_W'(i));
            head_oh[i] = (q_r[0] == LVL_W'(i));
        end

        if (do_pop) begin
            q_pp    = q_r >> LVL_W;
            cnt_pp  = cnt_r - CNT_W'(1);
            pend_pp = pend_r & ~head_oh;
        end

        is_dup  = |(pend_pp & req_oh);
        is_full = (cnt_pp == CNT_W'(DEPTH));

        q_nxt    = q_pp;
        cnt_nxt  = cnt_pp;
        pend_nxt = pend_pp;

        if (bus.add_new_lvl) begin
            if (oor) begin
                ovf_nxt = 1'b1;
            end else if (is_dup) begin
                dup_nxt = 1'b1;
            end else if (is_full) begin
                ovf_nxt = 1'b1;
            end else begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (cnt_pp == CNT_W'(i)) q_nxt[i] = bus.pressed_lvl;
                end
                cnt_nxt  = cnt_pp + CNT_W'(1);
                pend_nxt = pend_pp | req_oh;
            end
        end

        full_nxt  = (cnt_nxt == CNT_W'(DEPTH));
        empty_nxt = (cnt_nxt == '0);
        hv_nxt    = (cnt_nxt != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r     <= '0;
            cnt_r   <= '0;
            pend_r  <= '0;
            dup_r   <= 1'b0;
            ovf_r   <= 1'b0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
            hv_r    <= 1'b0;
        end else begin
            q_r     <= q_nxt;
            cnt_r   <= cnt_nxt;
            pend_r  <= pend_nxt;
            dup_r   <= dup_nxt;
            ovf_r   <= ovf_nxt;
            full_r  <= full_nxt;
            empty_r <= empty_nxt;
            hv_r    <= hv_nxt;
        end
    end

    assign bus.queue      = q_r;
    assign bus.count      = cnt_r;
    assign bus.head_lvl   = q_r[0];
    assign bus.head_valid = hv_r;
    assign bus.full       = full_r;
    assign bus.empty      = empty_r;
    assign bus.pending    = pend_r;
    assign bus.dup_drop   = dup_r;
    assign bus.ovf_drop   = ovf_r;
endmodule

// File: doc/elevator_request_queue.md
# elevator_request_queue

Registered, parametrised FIFO of pending elevator floor requests, the sequential successor to the combinational add-path logic. Accepts button presses, suppresses duplicates of already-pending floors, and presents the oldest request to the car controller, which retires it with `pop`. Sits between the button-scan front end and the motion controller. Number of floors and queue depth are generic.

## Interface
- `NUM_LVLS`, default 4: number of floors; valid levels are 0..NUM_LVLS-1.
- `DEPTH`, default 4: queue entries; must be between 1 and NUM_LVLS.
- `LVL_W`, default $clog2(NUM_LVLS) with a minimum of 1: level field width (derived, not overridden).
- `CNT_W`, default $clog2(DEPTH+1): occupancy width (derived).
- `clk`  in  1  rising-edge clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `add_new_lvl`  in  1  request strobe, sampled each clock.
- `pressed_lvl`  in  LVL_W  floor being requested.
- `pop`  in  1  controller has served the head entry.
- `queue`  out  DEPTH*LVL_W  flat entries; entry i is at bits [i*LVL_W +: LVL_W]; entry 0 is the head.
- `count`  out  CNT_W  number of valid entries; also the tail index.
- `head_lvl`  out  LVL_W  equals entry 0.
- `head_valid`  out  1  high when count != 0.
- `full`  out  1  high when count == DEPTH.
- `empty`  out  1  high when count == 0.
- `pending`  out  NUM_LVLS  one-hot-per-floor mask of the levels currently in the queue.
- `dup_drop`  out  1  one-cycle pulse: request dropped as a duplicate.
- `ovf_drop`  out  1  one-cycle pulse: request dropped because the queue was full or the level was out of range.

## Operation
- Reset (async assert, synchronous-to-clk release): all queue entries 0, `count`=0, `pending`=0, `dup_drop`=`ovf_drop`=0, so `empty`=1, `full`=0, `head_valid`=0, `head_lvl`=0.
- Storage is a shift queue. Entries at index count and above are always held at 0.
- Pop with count>0: entries shift down by one (entry i takes entry i+1), the top entry is cleared, `count` decrements, and the head's bit in `pending` clears. Pop with count==0 is ignored silently.
- Add with no pop:
  - Out-of-range level (pressed_lvl >= NUM_LVLS): dropped, `ovf_drop` pulses.
  - Level already pending: dropped, `dup_drop` pulses.
  - count==DEPTH: dropped, `ovf_drop` pulses.
  - Otherwise the level is written at entry `count`, `count` increments, and its bit in `pending` sets.
- Add and pop in the same cycle (count>0):
  - Pop takes effect first.
  - The duplicate check runs against the post-pop contents, so re-requesting the departing head floor is accepted.
  - The full check uses count-1, so an add on a full queue that is also popping is accepted.
  - An accepted add is written at entry count-1; `count` is unchanged.
- Add and pop on an empty queue: the pop is ignored and the add proceeds as a plain add.
- Drop priority when several reasons apply: out-of-range, then duplicate, then full. At most one drop flag pulses per cycle.
- Invariant: the entries are pairwise distinct. Because DEPTH <= NUM_LVLS, duplicate suppression means `full` is reached only when DEPTH distinct floors are pending.

## Timing
- All outputs are registered. An input sampled at edge k is reflected in the outputs immediately after edge k (one-cycle latency).
- `head_lvl`/`head_valid` after a pop show the new head from the same edge.
- `dup_drop`/`ovf_drop` are high for exactly the one cycle following the offending edge and return to 0 unless re-triggered.
- Asserting `rst_n` low mid-operation clears the state immediately, without waiting for a clock edge. Any request in flight is lost.
- No combinational path exists from inputs to outputs.

## Test plan
All scenarios use the defaults NUM_LVLS=4, DEPTH=4.
1. Reset, then idle for 2 cycles -> `queue`=8'b00000000, `count`=0, `empty`=1, `head_valid`=0, `pending`=4'b0000.
2. Add 2, then add 1 on consecutive cycles -> after the first edge `queue`=8'b00000010; after the second `queue`=8'b00000110, `count`=2, `pending`=4'b0110, `head_lvl`=2.
3. From queue [2,1], add 2 -> `dup_drop` pulses for one cycle and the queue is unchanged. Then add 2 together with pop -> `queue`=8'b00001001 ([1,2]), `count`=2, no drop flags.
4. Fill with 0,1,2,3 -> `full`=1, `queue`=8'b11100100. Then add 3 -> `dup_drop`=1. Then pop -> `queue`=8'b00111001, `count`=3, `full`=0.
5. Full queue [0,1,2,3], pop together with add 0 -> `queue`=8'b00111001 becomes [1,2,3,0] = 8'b00111001 with the top entry 0; `count`=4, `ovf_drop`=0.
6. Queue [2,1], pulse `rst_n` low between clock edges -> all outputs return to their reset values immediately. Pop on empty -> no change and no flags.
